mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/mem_arbiter_if.sv | 29 ++
 rtl/mem_arbiter_arb_rr2.sv | 11 +
 rtl/mem_arbiter.sv | 104 ++++++++++
 tb/tb_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the two-port (I-cache / D-cache) memory arbiter.
package mem_arbiter_pkg;
   localparam int DEF_MEM_LATENCY = 4;
   localparam int DEF_LINE_W      = 64;
   localparam int ADDR_W          = 16;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   typedef struct packed {
      logic              gnt_d;
      logic [ADDR_W-1:0] addr;
   } xfer_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side request/response and memory control signals of the arbiter.
interface mem_arbiter_if import mem_arbiter_pkg::*; #(
   parameter int LINE_W = DEF_LINE_W
) ();
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic [LINE_W-1:0] i_rdata;
   logic              i_done;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [LINE_W-1:0] d_wdata;
   logic [LINE_W-1:0] d_rdata;
   logic              d_done;
   logic              readM;
   logic              writeM;
   logic [ADDR_W-1:0] address;
   logic              busy;

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
      input  i_rdata, i_done, d_rdata, d_done, readM, writeM, address, busy
   );

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
      output i_rdata, i_done, d_rdata, d_done, readM, writeM, address, busy
   );
endinterface

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-way round-robin tie-break: on a tie, grant whoever was not granted last.
module arb_rr2 (
   input  logic req_i,
   input  logic req_d,
   input  logic last_d,
   output logic grant_d,
   output logic grant_valid
);
   assign grant_valid = req_i | req_d;
   assign grant_d     = req_d & (~req_i | ~last_d);
endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-cache and D-cache line transfers onto one shared memory bus,
// with a fixed-latency access phase and a one-cycle completion pulse.
module mem_arbiter import mem_arbiter_pkg::*; #(
   parameter int MEM_LATENCY = DEF_MEM_LATENCY,
   parameter int LINE_W      = DEF_LINE_W
) (
   input  logic              clk,
   input  logic              reset_n,
   mem_arbiter_if.slave      bus,
   inout  wire  [LINE_W-1:0] data
);
   logic [1:0]        state;
   logic [3:0]        cnt;
   logic              last_d;
   xfer_t             xfer;
   logic [LINE_W-1:0] wdata_q;
   logic [LINE_W-1:0] i_rdata_q, d_rdata_q;
   logic              read_q, write_q, i_done_q, d_done_q, busy_q;
   logic              grant_d, grant_valid;

   arb_rr2 u_arb (
      .req_i       (bus.i_req),
      .req_d       (bus.d_req),
      .last_d      (last_d),
      .grant_d     (grant_d),
      .grant_valid (grant_valid)
   );

   // reset_n is active-high despite its name
   always_ff @(posedge clk) begin
      if (reset_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         last_d    <= 1'b0;
         xfer      <= '0;
         wdata_q   <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
         read_q    <= 1'b0;
         write_q   <= 1'b0;
         i_done_q  <= 1'b0;
         d_done_q  <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         i_done_q <= 1'b0;
         d_done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (grant_valid) begin
                  xfer.gnt_d <= grant_d;
                  xfer.addr  <= grant_d ? bus.d_addr : bus.i_addr;
                  wdata_q    <= bus.d_wdata;
                  read_q     <= ~(grant_d & bus.d_we);
                  write_q    <= grant_d & bus.d_we;
                  cnt        <= 4'(MEM_LATENCY);
                  last_d     <= grant_d;
                  busy_q     <= 1'b1;
                  state      <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (cnt == 4'd1) begin
                  // memory data is valid at the edge closing the last access cycle
                  if (read_q) begin
                     if (xfer.gnt_d) d_rdata_q <= data;
                     else            i_rdata_q <= data;
                  end
                  read_q    <= 1'b0;
                  write_q   <= 1'b0;
                  xfer.addr <= '0;
                  cnt       <= '0;
                  i_done_q  <= ~xfer.gnt_d;
                  d_done_q  <= xfer.gnt_d;
                  state     <= S_DONE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_DONE: begin
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end
            default: begin
               read_q    <= 1'b0;
               write_q   <= 1'b0;
               xfer.addr <= '0;
               busy_q    <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

   assign data = write_q ? wdata_q : {LINE_W{1'bz}};

   assign bus.i_rdata = i_rdata_q;
   assign bus.d_rdata = d_rdata_q;
   assign bus.i_done  = i_done_q;
   assign bus.d_done  = d_done_q;
   assign bus.readM   = read_q;
   assign bus.writeM  = write_q;
   assign bus.address = xfer.addr;
   assign bus.busy    = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transfers queue their expected
// completion; a negedge monitor checks strobes, timing and read data.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int          L     = 4;
   localparam logic [63:0] PROBE = 64'hA5A5_5A5A_F00D_CAFE;

   typedef struct {
      bit          is_d;
      bit          is_wr;
      logic [15:0] addr;
      logic [63:0] wdata;
      int          done_cyc;
      logic [63:0] ird;
      logic [63:0] drd;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        probe_en = 1'b0;
   logic [63:0] mem_q, mem1_q;
   wire  [63:0] data, data1;
   int          cyc = 0;
   int          checks = 0, fails = 0;
   int          strb_n = 0, n_idone = 0, n_ddone = 0;
   logic [63:0] exp_i = '0, exp_d = '0;
   exp_t        q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_arbiter_if bus ();
   mem_arbiter_if bus1 ();

   mem_arbiter #(.MEM_LATENCY(L), .LINE_W(64)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus), .data(data)
   );
   mem_arbiter #(.MEM_LATENCY(1), .LINE_W(64)) dut1 (
      .clk(clk), .reset_n(reset_n), .bus(bus1), .data(data1)
   );

   function automatic logic [63:0] mem_rd(logic [15:0] a);
      if (a == 16'h0010) return 64'h1111_2222_3333_4444;
      return {16'hC0DE, a, ~a, 16'h1234};
   endfunction

   // memory model answers reads; probe_en lets the bench check the bus is released
   always_comb mem_q  = mem_rd(bus.address);
   always_comb mem1_q = mem_rd(bus1.address);
   assign data  = bus.readM ? mem_q : (probe_en ? PROBE : {64{1'bz}});
   assign data1 = bus1.readM ? mem1_q : {64{1'bz}};

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(bit is_d, bit is_wr, logic [15:0] a, logic [63:0] wd, int dc);
      exp_t e;
      if (!is_wr) begin
         if (is_d) exp_d = mem_rd(a);
         else      exp_i = mem_rd(a);
      end
      e.is_d = is_d; e.is_wr = is_wr; e.addr = a; e.wdata = wd;
      e.done_cyc = dc; e.ird = exp_i; e.drd = exp_d;
      q.push_back(e);
   endtask

   // drain the scoreboard, dropping each req on its done, then step into IDLE
   task automatic serve(int budget);
      int k = 0;
      while (q.size() != 0 && k < budget) begin
         @(negedge clk); #1;
         if (bus.i_done) bus.i_req = 1'b0;
         if (bus.d_done) bus.d_req = 1'b0;
         k++;
      end
      checks++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL serve_timeout: %0d transfers pending after %0d cycles", q.size(), budget);
         q.delete();
         bus.i_req = 1'b0;
         bus.d_req = 1'b0;
      end
      @(negedge clk); #1;
   endtask

   // monitor
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (reset_n) begin
         strb_n = 0;
      end else begin
         chk("rd_wr_excl", 64'(bus.readM & bus.writeM), 64'd0);
         if (!bus.busy) chk("idle_addr", 64'(bus.address), 64'd0);
         if ((bus.readM || bus.writeM) && q.size() != 0) begin
            strb_n++;
            chk("acc_addr", 64'(bus.address), 64'(q[0].addr));
            chk("acc_kind", 64'(bus.readM), 64'(!q[0].is_wr));
            if (bus.writeM) chk("wr_data", data, q[0].wdata);
         end
         if (bus.i_done || bus.d_done) begin
            if (bus.i_done) n_idone++;
            if (bus.d_done) n_ddone++;
            if (q.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexp_done: i_done=%0b d_done=%0b with nothing expected (cyc %0d)",
                        bus.i_done, bus.d_done, cyc);
            end else begin
               e = q.pop_front();
               chk("done_who", 64'({bus.i_done, bus.d_done}), e.is_d ? 64'd1 : 64'd2);
               chk("done_cyc", 64'(cyc), 64'(e.done_cyc));
               chk("strb_len", 64'(strb_n), 64'(L));
               chk("i_rdata", bus.i_rdata, e.ird);
               chk("d_rdata", bus.d_rdata, e.drd);
            end
            strb_n = 0;
         end
      end
   end

   initial begin
      int c, k, n0, n1, strb, dc;
      bit got;
      bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
      bus1.i_req = 0; bus1.i_addr = '0; bus1.d_req = 0; bus1.d_we = 0; bus1.d_addr = '0; bus1.d_wdata = '0;

      // reset state
      probe_en = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy",   64'(bus.busy), 64'd0);
      chk("rst_readM",  64'(bus.readM), 64'd0);
      chk("rst_writeM", 64'(bus.writeM), 64'd0);
      chk("rst_done",   64'({bus.i_done, bus.d_done}), 64'd0);
      chk("rst_addr",   64'(bus.address), 64'd0);
      chk("rst_irdata", bus.i_rdata, 64'd0);
      chk("rst_drdata", bus.d_rdata, 64'd0);
      chk("rst_bus_z",  data, PROBE);
      probe_en = 1'b0;
      reset_n = 1'b0;
      @(negedge clk); #1;

      // I read alone
      bus.i_addr = 16'h0010; bus.i_req = 1'b1;
      push(0, 0, 16'h0010, '0, cyc + 1 + L);
      serve(40);

      // D read, so the following write has a nonzero d_rdata to preserve
      bus.d_addr = 16'h0020; bus.d_we = 1'b0; bus.d_req = 1'b1;
      push(1, 0, 16'h0020, '0, cyc + 1 + L);
      serve(40);

      // D write, then the bus must be released
      bus.d_addr = 16'h0040; bus.d_we = 1'b1; bus.d_wdata = 64'hDEAD_BEEF_0000_0001; bus.d_req = 1'b1;
      push(1, 1, 16'h0040, 64'hDEAD_BEEF_0000_0001, cyc + 1 + L);
      serve(40);
      bus.d_we = 1'b0;
      probe_en = 1'b1; #1;
      chk("wr_bus_z", data, PROBE);
      probe_en = 1'b0;

      // back-to-back I reads: one IDLE cycle between transfers
      n0 = n_ddone; n1 = n_idone;
      bus.i_addr = 16'h0000; bus.i_req = 1'b1;
      push(0, 0, 16'h0000, '0, cyc + 1 + L);
      got = 0;
      for (k = 0; k < 30 && !got; k++) begin
         @(negedge clk); #1;
         got = bus.i_done;
      end
      chk("b2b_first_done", 64'(got), 64'd1);
      bus.i_addr = 16'h0004;
      push(0, 0, 16'h0004, '0, cyc + 2 + L);
      serve(40);
      chk("b2b_i_dones", 64'(n_idone - n1), 64'd2);
      chk("b2b_no_d_done", 64'(n_ddone - n0), 64'd0);

      // reset during the 2nd access cycle of a D read
      bus.d_addr = 16'h0500; bus.d_we = 1'b0; bus.d_req = 1'b1;
      @(negedge clk); #1;
      @(negedge clk); #1;
      chk("abort_pre_readM", 64'(bus.readM), 64'd1);
      reset_n = 1'b1; bus.d_req = 1'b0;
      exp_i = '0; exp_d = '0;
      @(negedge clk); #1;
      reset_n = 1'b0;
      chk("abort_busy",   64'(bus.busy), 64'd0);
      chk("abort_readM",  64'(bus.readM), 64'd0);
      chk("abort_drdata", bus.d_rdata, 64'd0);
      n0 = n_ddone;
      repeat (L + 2) @(negedge clk);
      #1;
      chk("abort_no_d_done", 64'(n_ddone - n0), 64'd0);

      // tie after reset: D first, I in the IDLE after D's DONE
      bus.i_addr = 16'h0100; bus.d_addr = 16'h0200; bus.d_we = 1'b0;
      bus.i_req = 1'b1; bus.d_req = 1'b1;
      c = cyc;
      push(1, 0, 16'h0200, '0, c + 1 + L);
      push(0, 0, 16'h0100, '0, c + 3 + 2 * L);
      serve(60);

      // D write leaves D as last granted, so the next tie goes to I
      bus.d_addr = 16'h0300; bus.d_we = 1'b1; bus.d_wdata = 64'h0123_4567_89AB_CDEF; bus.d_req = 1'b1;
      push(1, 1, 16'h0300, 64'h0123_4567_89AB_CDEF, cyc + 1 + L);
      serve(40);
      bus.d_we = 1'b0;

      bus.i_addr = 16'h0400; bus.d_addr = 16'h0600;
      bus.i_req = 1'b1; bus.d_req = 1'b1;
      c = cyc;
      push(0, 0, 16'h0400, '0, c + 1 + L);
      push(1, 0, 16'h0600, '0, c + 3 + 2 * L);
      serve(60);

      // MEM_LATENCY=1 instance
      bus1.i_addr = 16'h0010; bus1.i_req = 1'b1;
      c = cyc; strb = 0; got = 0; dc = -1;
      for (k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (bus1.readM) strb++;
         if (bus1.i_done) begin got = 1; dc = cyc; end
      end
      bus1.i_req = 1'b0;
      chk("l1_done_seen", 64'(got), 64'd1);
      chk("l1_done_cyc",  64'(dc), 64'(c + 2));
      chk("l1_strb_len",  64'(strb), 64'd1);
      chk("l1_i_rdata",   bus1.i_rdata, 64'h1111_2222_3333_4444);
      chk("l1_no_d_done", 64'(bus1.d_done), 64'd0);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
endmodule
